vx_csr_access_ctrl: RTL and testbench

- Initiator side of the core CSR access interface. Accepts CSR instructions (CSRRW/CSRRS/CSRRC, register or immediate source) from SFU dispatch.
- Sequences each instruction as a read of the CSR data block, then a read-modify-write, then a write. Returns the old CSR value to writeback.
- Sits between SFU dispatch and the CSR data block, one instance per core.
- Processes one instruction at a time through a 4-state FSM with valid/ready handshakes on both request and response.

---
 rtl/vx_csr_pkg.sv | 23 ++
 rtl/vx_csr_rmw_alu.sv | 28 ++
 rtl/vx_csr_access_ctrl.sv | 145 ++++++++++++++
 tb/tb_vx_csr_access_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_csr_pkg.sv
// Shared types for the CSR access controller: op encoding, FSM states and
// the read-only CSR address space marker.
package vx_csr_pkg;

  // 2'b00 is not a legal op; it behaves like a read-only RS.
  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_WRITE = 2'b10,
    S_RSP   = 2'b11
  } csr_state_t;

  // addr[11:10] value that marks the read-only CSR space
  localparam logic [1:0] CSR_RO_SPACE = 2'b11;

endpackage

// File: rtl/vx_csr_rmw_alu.sv
// Read-modify-write datapath for CSR instructions: computes the new CSR
// value and whether the instruction needs a write at all.
module vx_csr_rmw_alu
  import vx_csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  csr_op_t         i_op,
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_src,
  input  logic            i_src_zero,
  output logic [XLEN-1:0] o_new,
  output logic            o_do_write
);

  // RW replaces, RS sets bits, RC clears bits; illegal op falls into RS.
  always_comb begin
    o_new = i_old | i_src;
    case (i_op)
      CSR_RW:  o_new = i_src;
      CSR_RC:  o_new = i_old & ~i_src;
      default: o_new = i_old | i_src;
    endcase
    // RS/RC with a zero source never write; illegal op never writes.
    o_do_write = (i_op == CSR_RW) || ((i_op != CSR_NONE) && !i_src_zero);
  end

endmodule

// File: rtl/vx_csr_access_ctrl.sv
// CSR access controller: sequences each CSR instruction as read, optional
// write, then a response carrying the old value to writeback.
// Optional feature macro VX_CSR_RO_TRAP_EN: suppresses writes into the
// read-only space (addr[11:10]==2'b11) and flags them on rsp_error.
module vx_csr_access_ctrl
  import vx_csr_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UUID_W = 44,
  parameter int NW_W   = 2,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [UUID_W-1:0] req_uuid,
  input  logic [NW_W-1:0]   req_wid,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_src,
  input  logic              req_src_zero,
  input  logic              req_rd_zero,
  output logic              csr_read_enable,
  output logic [UUID_W-1:0] csr_read_uuid,
  output logic [NW_W-1:0]   csr_read_wid,
  output logic [ADDR_W-1:0] csr_read_addr,
  input  logic [XLEN-1:0]   csr_read_data_ro,
  input  logic [XLEN-1:0]   csr_read_data_rw,
  output logic              csr_write_enable,
  output logic [UUID_W-1:0] csr_write_uuid,
  output logic [NW_W-1:0]   csr_write_wid,
  output logic [ADDR_W-1:0] csr_write_addr,
  output logic [XLEN-1:0]   csr_write_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [UUID_W-1:0] rsp_uuid,
  output logic [NW_W-1:0]   rsp_wid,
`ifdef VX_CSR_RO_TRAP_EN
  output logic              rsp_error,
`endif
  output logic [XLEN-1:0]   rsp_data
);

  csr_state_t        r_state, w_next;
  logic [UUID_W-1:0] r_uuid;
  logic [NW_W-1:0]   r_wid;
  csr_op_t           r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_src;
  logic              r_src_zero;
  logic              r_rd_zero;
  logic [XLEN-1:0]   r_new;
  logic [XLEN-1:0]   r_rsp_data;
  logic              r_err;

  logic [XLEN-1:0]   w_old;
  logic [XLEN-1:0]   w_new;
  logic              w_alu_write;
  logic              w_do_write;
  logic              w_ro_hit;

  assign w_old = csr_read_data_ro | csr_read_data_rw;

  vx_csr_rmw_alu #(.XLEN(XLEN)) u_alu (
    .i_op       (r_op),
    .i_old      (w_old),
    .i_src      (r_src),
    .i_src_zero (r_src_zero),
    .o_new      (w_new),
    .o_do_write (w_alu_write)
  );

`ifdef VX_CSR_RO_TRAP_EN
  assign w_ro_hit   = w_alu_write && (r_addr[ADDR_W-1:ADDR_W-2] == CSR_RO_SPACE);
  assign w_do_write = w_alu_write && !w_ro_hit;
  assign rsp_error  = r_err;
`else
  assign w_ro_hit   = 1'b0;
  assign w_do_write = w_alu_write;
`endif

  // State register; reset aborts any in-flight instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = S_READ;
      S_READ:  w_next = w_do_write ? S_WRITE : S_RSP;
      S_WRITE: w_next = S_RSP;
      S_RSP:   if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the instruction on accept; capture old/new values during READ.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_uuid     <= '0;
      r_wid      <= '0;
      r_op       <= CSR_NONE;
      r_addr     <= '0;
      r_src      <= '0;
      r_src_zero <= 1'b0;
      r_rd_zero  <= 1'b0;
      r_new      <= '0;
      r_rsp_data <= '0;
      r_err      <= 1'b0;
    end else if (r_state == S_IDLE && req_valid) begin
      r_uuid     <= req_uuid;
      r_wid      <= req_wid;
      r_op       <= csr_op_t'(req_op);
      r_addr     <= req_addr;
      r_src      <= req_src;
      r_src_zero <= req_src_zero;
      r_rd_zero  <= req_rd_zero;
    end else if (r_state == S_READ) begin
      r_new      <= w_new;
      // rd==x0 still retires through writeback, just with no data
      r_rsp_data <= r_rd_zero ? '0 : w_old;
      r_err      <= w_ro_hit;
    end
  end

  assign req_ready        = (r_state == S_IDLE);
  assign csr_read_enable  = (r_state == S_READ);
  assign csr_read_uuid    = r_uuid;
  assign csr_read_wid     = r_wid;
  assign csr_read_addr    = r_addr;
  assign csr_write_enable = (r_state == S_WRITE);
  assign csr_write_uuid   = r_uuid;
  assign csr_write_wid    = r_wid;
  assign csr_write_addr   = r_addr;
  assign csr_write_data   = r_new;
  assign rsp_valid        = (r_state == S_RSP);
  assign rsp_uuid         = r_uuid;
  assign rsp_wid          = r_wid;
  assign rsp_data         = r_rsp_data;

endmodule

// File: tb/tb_vx_csr_access_ctrl.sv
// Scoreboard bench for vx_csr_access_ctrl: the driver pushes the expected
// transaction on accept, the monitor checks read/write strobes and responses.
module tb_vx_csr_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [43:0] req_uuid = '0;
  logic [1:0]  req_wid = '0;
  logic [1:0]  req_op = '0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_src = '0;
  logic        req_src_zero = 1'b0;
  logic        req_rd_zero = 1'b0;
  logic        csr_read_enable;
  logic [43:0] csr_read_uuid;
  logic [1:0]  csr_read_wid;
  logic [11:0] csr_read_addr;
  logic [31:0] csr_read_data_ro = '0;
  logic [31:0] csr_read_data_rw = '0;
  logic        csr_write_enable;
  logic [43:0] csr_write_uuid;
  logic [1:0]  csr_write_wid;
  logic [11:0] csr_write_addr;
  logic [31:0] csr_write_data;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [43:0] rsp_uuid;
  logic [1:0]  rsp_wid;
  logic [31:0] rsp_data;
`ifdef VX_CSR_RO_TRAP_EN
  logic        rsp_error;
`endif

  vx_csr_access_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_uuid(req_uuid),
    .req_wid(req_wid), .req_op(req_op), .req_addr(req_addr), .req_src(req_src),
    .req_src_zero(req_src_zero), .req_rd_zero(req_rd_zero),
    .csr_read_enable(csr_read_enable), .csr_read_uuid(csr_read_uuid),
    .csr_read_wid(csr_read_wid), .csr_read_addr(csr_read_addr),
    .csr_read_data_ro(csr_read_data_ro), .csr_read_data_rw(csr_read_data_rw),
    .csr_write_enable(csr_write_enable), .csr_write_uuid(csr_write_uuid),
    .csr_write_wid(csr_write_wid), .csr_write_addr(csr_write_addr),
    .csr_write_data(csr_write_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_uuid(rsp_uuid),
    .rsp_wid(rsp_wid),
`ifdef VX_CSR_RO_TRAP_EN
    .rsp_error(rsp_error),
`endif
    .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        dw;
    logic [31:0] rdata;
    logic [43:0] uuid;
    logic [1:0]  wid;
    logic        err;
    int          rcyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   in_rsp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Monitor: checks strobes and responses against the queue head.
  always @(negedge clk) begin
    if (!reset_n) in_rsp = 1'b0;
    else begin
      if (csr_read_enable && csr_write_enable) flag("rd_wr_overlap");
      if (csr_read_enable) begin
        if (exp_q.size() == 0) flag("unexpected_read");
        else begin
          chk("rd_addr", 64'(csr_read_addr), 64'(exp_q[0].addr));
          chk("rd_uuid", 64'(csr_read_uuid), 64'(exp_q[0].uuid));
          chk("rd_cycle", 64'(cyc), 64'(exp_q[0].rcyc));
        end
      end
      if (csr_write_enable) begin
        if (exp_q.size() == 0) flag("unexpected_write");
        else begin
          chk("wr_expected", 64'(1), 64'(exp_q[0].dw));
          chk("wr_data", 64'(csr_write_data), 64'(exp_q[0].wdata));
          chk("wr_addr", 64'(csr_write_addr), 64'(exp_q[0].addr));
          chk("wr_wid", 64'(csr_write_wid), 64'(exp_q[0].wid));
          chk("wr_cycle", 64'(cyc), 64'(exp_q[0].rcyc + 1));
        end
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) flag("unexpected_rsp");
        else begin
          if (!in_rsp) chk("rsp_cycle", 64'(cyc), 64'(exp_q[0].rcyc + (exp_q[0].dw ? 2 : 1)));
          in_rsp = 1'b1;
          chk("rsp_data", 64'(rsp_data), 64'(exp_q[0].rdata));
          chk("rsp_uuid", 64'(rsp_uuid), 64'(exp_q[0].uuid));
          chk("rsp_wid", 64'(rsp_wid), 64'(exp_q[0].wid));
          chk("req_ready_in_rsp", 64'(req_ready), 64'(0));
`ifdef VX_CSR_RO_TRAP_EN
          chk("rsp_error", 64'(rsp_error), 64'(exp_q[0].err));
`endif
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            in_rsp = 1'b0;
          end
        end
      end
    end
  end

  int uid = 1;

  // Drive one instruction at posedge+1; push expectation after the accept edge.
  task automatic send(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] src,
                      input logic sz, input logic rz, input logic [31:0] ro, input logic [31:0] rw,
                      input logic [31:0] wdata, input logic dw, input logic [31:0] rdata,
                      input logic err);
    exp_t e;
    int   n = 0;
    while (!req_ready && n < 30) begin @(posedge clk); #1; n++; end
    if (!req_ready) flag("req_ready_timeout");
    req_uuid = 44'(uid); req_wid = 2'(uid % 4); req_op = op; req_addr = addr;
    req_src = src; req_src_zero = sz; req_rd_zero = rz;
    csr_read_data_ro = ro; csr_read_data_rw = rw;
    req_valid = 1'b1;
    @(posedge clk); #1;
    e.addr = addr; e.wdata = wdata; e.dw = dw; e.rdata = rdata;
    e.uuid = 44'(uid); e.wid = 2'(uid % 4); e.err = err; e.rcyc = cyc;
    exp_q.push_back(e);
    req_valid = 1'b0;
    uid++;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
    if (exp_q.size() != 0) begin
      flag("drain_timeout");
      exp_q.delete();
    end
  endtask

  initial begin
    int n;
    exp_t e;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rd_en", 64'(csr_read_enable), 64'(0));
    chk("rst_wr_en", 64'(csr_write_enable), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("rst_wr_data", 64'(csr_write_data), 64'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;

    // RW: write new value, return old
    send(2'b01, 12'h340, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h1234, 32'hDEAD_BEEF, 1'b1, 32'h1234, 1'b0);
    wait_done();
    // RS with zero source: read only
    send(2'b10, 12'hF14, 32'h0, 1'b1, 1'b0, 32'h3, 32'h0, 32'h0, 1'b0, 32'h3, 1'b0);
    wait_done();
    // RC clears low nibble
    send(2'b11, 12'h344, 32'h0F, 1'b0, 1'b0, 32'h0, 32'hFF, 32'hF0, 1'b1, 32'hFF, 1'b0);
    wait_done();
    // RS with rd=x0: write happens, response data forced to zero
    send(2'b10, 12'h300, 32'h100, 1'b0, 1'b1, 32'h0, 32'h11, 32'h111, 1'b1, 32'h0, 1'b0);
    wait_done();
    // illegal op 00: read only even with non-zero source
    send(2'b00, 12'h305, 32'h55, 1'b0, 1'b0, 32'h0, 32'h7, 32'h0, 1'b0, 32'h7, 1'b0);
    wait_done();

    // Backpressure: response held 5 cycles, second request waits for handshake
    rsp_ready = 1'b0;
    send(2'b01, 12'h300, 32'hA, 1'b0, 1'b0, 32'h0, 32'hB, 32'hA, 1'b1, 32'hB, 1'b0);
    n = 0;
    while (!rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
    if (!rsp_valid) flag("bp_rsp_timeout");
    req_uuid = 44'(uid); req_wid = 2'(uid % 4); req_op = 2'b11; req_addr = 12'h301;
    req_src = 32'h1; req_src_zero = 1'b0; req_rd_zero = 1'b0;
    req_valid = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_after_hs", 64'(req_ready), 64'(1));
    e.addr = 12'h301; e.wdata = 32'hA; e.dw = 1'b1; e.rdata = 32'hB;
    e.uuid = 44'(uid); e.wid = 2'(uid % 4); e.err = 1'b0; e.rcyc = cyc + 1;
    exp_q.push_back(e);
    uid++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_done();

    // Reset during WRITE aborts: strobe drops, no response
    send(2'b01, 12'h342, 32'h77, 1'b0, 1'b0, 32'h0, 32'h1, 32'h77, 1'b1, 32'h1, 1'b0);
    n = 0;
    while (!csr_write_enable && n < 10) begin @(posedge clk); #1; n++; end
    if (!csr_write_enable) flag("abort_no_write");
    reset_n = 1'b0;
    #1;
    chk("abort_wr_en", 64'(csr_write_enable), 64'(0));
    chk("abort_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("abort_req_ready", 64'(req_ready), 64'(1));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("post_rst_req_ready", 64'(req_ready), 64'(1));
    end

    // recovery after abort
    send(2'b01, 12'h005, 32'h9, 1'b0, 1'b0, 32'h0, 32'h0, 32'h9, 1'b1, 32'h0, 1'b0);
    wait_done();

    // RW into read-only space
`ifdef VX_CSR_RO_TRAP_EN
    send(2'b01, 12'hC00, 32'h5, 1'b0, 1'b0, 32'h77, 32'h0, 32'h5, 1'b0, 32'h77, 1'b1);
`else
    send(2'b01, 12'hC00, 32'h5, 1'b0, 1'b0, 32'h77, 32'h0, 32'h5, 1'b1, 32'h77, 1'b0);
`endif
    wait_done();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
